// File: rtl/x_datapath.sv
//------------------------------------------------------------------------------
// x_datapath : shift-add multiplier datapath with five-entry register file,
//              single-cycle ALU, product capture and sticky control-error flag.
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module x_datapath #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic [4:0]         rd_enA,
  input  logic [4:0]         rd_enB,
  input  logic [4:0]         wr_en,
  input  logic               ppgen_en,
  input  logic               add_en,
  input  logic               shift_en,
  input  logic               left_right,
  input  logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic               prod_valid,
  output logic               err
);

  localparam int DW   = 2 * WIDTH;
  localparam int NREG = 5;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] product_q, product_d;
  logic          prod_valid_q, prod_valid_d;
  logic          err_q, err_d;

  logic          a_onehot, b_onehot;
  logic          any_op, multi_op;
  logic          bad_a, bad_b, illegal;
  logic [DW-1:0] bus_a, bus_b, alu;

  always_comb begin
    a_onehot = (rd_enA != 5'd0) && ((rd_enA & (rd_enA - 5'd1)) == 5'd0);
    b_onehot = (rd_enB != 5'd0) && ((rd_enB & (rd_enB - 5'd1)) == 5'd0);
    any_op   = ppgen_en | add_en | shift_en;
    multi_op = (ppgen_en & add_en) | (ppgen_en & shift_en) | (add_en & shift_en);
    // An all-zero select is only tolerated when nothing consumes that bus.
    bad_a    = (rd_enA == 5'd0) ? (any_op || (wr_en != 5'd0)) : !a_onehot;
    bad_b    = (rd_enB == 5'd0) ? (ppgen_en | add_en) : !b_onehot;
    illegal  = bad_a | bad_b | multi_op;
  end

  always_comb begin
    bus_a = '0;
    bus_b = '0;
    for (int i = 0; i < NREG; i++) begin
      if (a_onehot && rd_enA[i]) bus_a = regs_q[i];
      if (b_onehot && rd_enB[i]) bus_b = regs_q[i];
    end
  end

  always_comb begin
    alu = bus_a;
    if (ppgen_en)      alu = bus_a & {DW{bus_b[0]}};
    else if (add_en)   alu = bus_a + bus_b;
    else if (shift_en) alu = left_right ? {bus_a[DW-2:0], 1'b0} : {1'b0, bus_a[DW-1:1]};
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (load) begin
      regs_d[0] = {{WIDTH{1'b0}}, op_a};
      regs_d[1] = {{WIDTH{1'b0}}, op_b};
      for (int i = 2; i < NREG; i++) regs_d[i] = '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_en[i]) regs_d[i] = alu;
      end
    end
    // Capture uses the pre-edge R2, so a concurrent load or write cannot leak in.
    product_d    = done ? regs_q[2] : product_q;
    prod_valid_d = done;
    err_d        = load ? 1'b0 : (err_q | illegal);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      product_q    <= '0;
      prod_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      product_q    <= product_d;
      prod_valid_q <= prod_valid_d;
      err_q        <= err_d;
    end
  end

  assign product    = product_q;
  assign prod_valid = prod_valid_q;
  assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_x_datapath.sv
//------------------------------------------------------------------------------
// tb_x_datapath : directed self-checking bench for x_datapath.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_x_datapath;

  localparam int WIDTH = 8;
  localparam logic [4:0] R0 = 5'b00001;
  localparam logic [4:0] R1 = 5'b00010;
  localparam logic [4:0] R2 = 5'b00100;
  localparam logic [4:0] R3 = 5'b01000;

  logic               clk = 1'b0;
  logic               rst;
  logic               load;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [4:0]         rd_enA, rd_enB, wr_en;
  logic               ppgen_en, add_en, shift_en, left_right, done;
  logic [2*WIDTH-1:0] product;
  logic               prod_valid, err;

  int checks = 0;
  int errors = 0;

  x_datapath #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load(load), .op_a(op_a), .op_b(op_b),
    .rd_enA(rd_enA), .rd_enB(rd_enB), .wr_en(wr_en),
    .ppgen_en(ppgen_en), .add_en(add_en), .shift_en(shift_en),
    .left_right(left_right), .done(done),
    .product(product), .prod_valid(prod_valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    load = 0; done = 0; rd_enA = 0; rd_enB = 0; wr_en = 0;
    ppgen_en = 0; add_en = 0; shift_en = 0; left_right = 0;
  endtask

  task automatic drv(input logic p, input logic a, input logic s, input logic lr,
                     input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] w);
    ppgen_en = p; add_en = a; shift_en = s; left_right = lr;
    rd_enA = ra; rd_enB = rb; wr_en = w;
    step();
    idle_ctl();
  endtask

  task automatic mv(input logic [4:0] src, input logic [4:0] dst);
    drv(0, 0, 0, 0, src, 5'd0, dst);
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] b);
    op_a = a; op_b = b; load = 1;
    step();
    load = 0;
  endtask

  task automatic cap(input string tag, input logic [15:0] exp);
    done = 1;
    step();
    done = 0;
    chk(tag, product, exp);
    chk({tag, "_pv"}, {15'd0, prod_valid}, 16'd1);
  endtask

  task automatic mult(input logic [7:0] a, input logic [7:0] b);
    do_load(a, b);
    for (int k = 0; k < WIDTH; k++) begin
      drv(1, 0, 0, 0, R0, R1, R3);
      drv(0, 1, 0, 0, R2, R3, R2);
      drv(0, 0, 1, 1, R0, 5'd0, R0);
      drv(0, 0, 1, 0, R1, 5'd0, R1);
    end
  endtask

  initial begin
    idle_ctl();
    op_a = 0; op_b = 0;
    rst = 0;
    // Reset with random controls
    for (int k = 0; k < 2; k++) begin
      load = 1'($urandom); done = 1'($urandom);
      rd_enA = 5'($urandom); rd_enB = 5'($urandom); wr_en = 5'($urandom);
      ppgen_en = 1'($urandom); add_en = 1'($urandom); shift_en = 1'($urandom);
      op_a = 8'($urandom); op_b = 8'($urandom);
      step();
    end
    idle_ctl();
    chk("rst_product", product, 16'h0);
    chk("rst_pv", {15'd0, prod_valid}, 16'h0);
    chk("rst_err", {15'd0, err}, 16'h0);
    rst = 1;
    step();
    chk("idle_product", product, 16'h0);
    chk("idle_pv", {15'd0, prod_valid}, 16'h0);
    chk("idle_err", {15'd0, err}, 16'h0);
    cap("rst_r2", 16'h0000);

    // Full multiplies
    mult(8'd3, 8'd5);
    chk("mul3x5_err", {15'd0, err}, 16'h0);
    cap("mul3x5", 16'h000F);
    step();
    chk("mul3x5_pv_off", {15'd0, prod_valid}, 16'h0);
    chk("mul3x5_hold", product, 16'h000F);
    mult(8'hFF, 8'hFF);
    cap("mulFFxFF", 16'hFE01);
    chk("mulFFxFF_err", {15'd0, err}, 16'h0);

    // Back-to-back done
    done = 1;
    step();
    chk("dd1_pv", {15'd0, prod_valid}, 16'h1);
    step();
    chk("dd2_pv", {15'd0, prod_valid}, 16'h1);
    chk("dd2_product", product, 16'hFE01);
    done = 0;
    step();
    chk("dd3_pv", {15'd0, prod_valid}, 16'h0);

    // Shift boundaries: build 0x8001 in R0 and R1
    do_load(8'h80, 8'h01);
    for (int k = 0; k < 8; k++) drv(0, 0, 1, 1, R0, 5'd0, R0);
    drv(0, 1, 0, 0, R0, R1, R0);
    mv(R0, R1);
    mv(R0, R2);
    cap("build_8001", 16'h8001);
    drv(0, 0, 1, 1, R0, 5'd0, R0);
    drv(0, 0, 1, 0, R1, 5'd0, R1);
    mv(R0, R2);
    cap("shl_8001", 16'h0002);
    mv(R1, R2);
    cap("shr_8001", 16'h4000);
    chk("shift_err", {15'd0, err}, 16'h0);

    // Add wrap-around
    do_load(8'hFF, 8'h01);
    mv(R0, R2);
    for (int k = 0; k < 8; k++) drv(0, 0, 1, 1, R0, 5'd0, R0);
    drv(0, 1, 0, 0, R0, R2, R2);
    mv(R1, R3);
    cap("build_FFFF", 16'hFFFF);
    drv(0, 1, 0, 0, R2, R3, R2);
    cap("add_wrap", 16'h0000);
    chk("add_wrap_err", {15'd0, err}, 16'h0);

    // Non-one-hot bus A select
    do_load(8'd3, 8'd5);
    chk("pre_illegal_err", {15'd0, err}, 16'h0);
    drv(0, 1, 0, 0, 5'b00011, R1, R2);
    chk("bad_sel_err", {15'd0, err}, 16'h1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bad_sel_sticky", {15'd0, err}, 16'h1);
    end
    cap("bad_sel_busA0", 16'h0005);
    do_load(8'd3, 8'd5);
    chk("load_clr_err", {15'd0, err}, 16'h0);

    // Two op enables at once: add wins, err sets
    drv(0, 1, 1, 1, R0, R1, R2);
    chk("multi_op_err", {15'd0, err}, 16'h1);
    cap("multi_op_prio", 16'h0008);
    do_load(8'd3, 8'd5);
    chk("load_clr_err2", {15'd0, err}, 16'h0);

    // Load overrides a concurrent (illegal) write
    op_a = 8'd7; op_b = 8'd2; load = 1;
    add_en = 1; rd_enA = 5'b00011; rd_enB = R1; wr_en = R0;
    step();
    idle_ctl();
    chk("load_wr_err", {15'd0, err}, 16'h0);
    mv(R0, R2);
    cap("load_wr_r0", 16'h0007);

    // done together with load
    op_a = 8'd9; op_b = 8'd4; load = 1; done = 1;
    step();
    idle_ctl();
    chk("done_load_product", product, 16'h0007);
    chk("done_load_pv", {15'd0, prod_valid}, 16'h1);
    cap("done_load_r2", 16'h0000);
    mv(R0, R2);
    cap("done_load_r0", 16'h0009);
    mv(R1, R2);
    cap("done_load_r1", 16'h0004);

    // Reset mid-sequence
    do_load(8'd3, 8'd5);
    for (int k = 0; k < 3; k++) begin
      drv(1, 0, 0, 0, R0, R1, R3);
      drv(0, 1, 0, 0, R2, R3, R2);
      drv(0, 0, 1, 1, R0, 5'd0, R0);
      drv(0, 0, 1, 0, R1, 5'd0, R1);
    end
    drv(0, 1, 0, 0, 5'b00110, R1, R2);
    chk("mid_err_set", {15'd0, err}, 16'h1);
    rst = 0; done = 1; load = 1; op_a = 8'hAA; op_b = 8'h55;
    add_en = 1; rd_enA = R2; rd_enB = R3; wr_en = 5'b11111;
    step();
    idle_ctl();
    chk("mid_rst_product", product, 16'h0);
    chk("mid_rst_pv", {15'd0, prod_valid}, 16'h0);
    chk("mid_rst_err", {15'd0, err}, 16'h0);
    rst = 1;
    cap("mid_rst_r2", 16'h0000);
    mv(R0, R2);
    cap("mid_rst_r0", 16'h0000);
    mv(R1, R2);
    cap("mid_rst_r1", 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
